// File: rtl/trace_uart_fifo.sv
// Trace character FIFO between the TRACE_REG write decode and the uart TX block.
// Buffers CPU trace bytes and drains them one at a time over the uart wr_strobe/busy handshake.
module trace_uart_fifo #(
  parameter int DEPTH          = 16,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_strobe_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   clear_overflow_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   uart_wr_strobe_o,
  output logic [7:0]             uart_data_o,
  input  logic                   uart_busy_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // One spare bit so the "hold <= 2" exit test is representable even when HOLDOFF_CYCLES is 1.
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_WAIT
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [HW-1:0] hold, hold_next;
  logic          full, empty, push, drop, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Push admission looks only at the count at the start of the cycle; a same-cycle pop does not help.
  assign push  = wr_strobe_i && !full;
  assign drop  = wr_strobe_i && full;

  always_comb begin
    state_next = state;
    hold_next  = hold;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && !uart_busy_i) begin
          pop        = 1'b1;
          hold_next  = HOLD_INIT;
          state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        hold_next = hold - HW'(1);
        if (hold <= HW'(2)) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!uart_busy_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      overflow_o       <= 1'b0;
      uart_wr_strobe_o <= 1'b0;
      uart_data_o      <= '0;
    end else begin
      count            <= count_next;
      uart_wr_strobe_o <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        uart_data_o <= mem[rd_ptr];
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = count;

endmodule

// File: tb/tb_trace_uart_fifo.sv
// Directed bench for trace_uart_fifo with a small uart busy model and an output byte monitor.
module tb_trace_uart_fifo;

  localparam int DEPTH = 16;
  localparam int HOLD  = 2;

  logic       clk_i = 1'b0;
  logic       rst_i, wr_strobe_i, clear_overflow_i;
  logic [7:0] wr_data_i;
  logic       full_o, empty_o, overflow_o, uart_wr_strobe_o, uart_busy_i;
  logic [7:0] uart_data_o;
  logic [4:0] level_o;

  int checks = 0;
  int errors = 0;

  trace_uart_fifo #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_strobe_i(wr_strobe_i), .wr_data_i(wr_data_i),
    .clear_overflow_i(clear_overflow_i), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .uart_wr_strobe_o(uart_wr_strobe_o),
    .uart_data_o(uart_data_o), .uart_busy_i(uart_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // uart model: busy for busy_len (or a random 0..6) cycles after each strobe
  logic force_busy = 1'b0;
  int   busy_len   = 0;
  bit   rand_busy  = 1'b0;
  int   busy_cnt   = 0;
  always @(posedge clk_i) begin
    if (rst_i) busy_cnt <= 0;
    else if (uart_wr_strobe_o) busy_cnt <= rand_busy ? int'($urandom_range(0, 6)) : busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy_i = force_busy | (busy_cnt != 0);

  logic [7:0] out_q[$];
  int         out_gap[$];
  int         last_busy = -100;
  bit         prev_strb = 1'b0;
  always @(negedge clk_i) begin
    if (uart_wr_strobe_o) begin
      out_q.push_back(uart_data_o);
      out_gap.push_back(cyc - last_busy);
      checks++;
      if (prev_strb) begin
        errors++;
        $display("FAIL strobe_spacing: strobe high in cycles %0d and %0d, required non-consecutive", cyc - 1, cyc);
      end
    end
    if (uart_busy_i) last_busy = cyc;
    prev_strb = uart_wr_strobe_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_strobe_i = 1'b1;
    wr_data_i   = d;
    tick();
    wr_strobe_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    for (int t = 0; t < budget && out_q.size() < n; t++) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++; if (uart_wr_strobe_o !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", uart_wr_strobe_o); end
    checks++; if (uart_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_data_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_q.delete(); out_gap.delete();
    busy_len = 0;
    push(8'h41);
    checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL single_level1: got %0d expected 1", level_o); end
    checks++; if (uart_wr_strobe_o !== 1'b0) begin errors++; $display("FAIL single_early_strobe: got %b expected 0", uart_wr_strobe_o); end
    tick();
    checks++; if (uart_wr_strobe_o !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", uart_wr_strobe_o); end
    checks++; if (uart_data_o !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", uart_data_o); end
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL single_level0: got %0d expected 0", level_o); end
    tick();
    checks++; if (uart_wr_strobe_o !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b expected 0", uart_wr_strobe_o); end
    checks++; if (uart_data_o !== 8'h41) begin errors++; $display("FAIL single_data_hold: got %h expected 41", uart_data_o); end
    repeat (6) tick();
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d strobes expected 1", out_q.size()); end
  endtask

  task automatic test_abc();
    int peak;
    out_q.delete(); out_gap.delete();
    busy_len = 10;
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      push(8'h41 + 8'(i));
      if (int'(level_o) > peak) peak = int'(level_o);
    end
    for (int t = 0; t < 300 && out_q.size() < 3; t++) begin
      tick();
      if (int'(level_o) > peak) peak = int'(level_o);
    end
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL abc_count: got %0d bytes expected 3", out_q.size()); end
    if (out_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_q[i] !== 8'h41 + 8'(i)) begin errors++; $display("FAIL abc_order[%0d]: got %h expected %h", i, out_q[i], 8'h41 + 8'(i)); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (out_gap[i] < HOLD + 1) begin errors++; $display("FAIL abc_gap[%0d]: got %0d cycles expected >= %0d", i, out_gap[i], HOLD + 1); end
      end
    end
    checks++; if (peak != 2) begin errors++; $display("FAIL abc_peak_level: got %0d expected 2", peak); end
    repeat (20) tick();
  endtask

  task automatic test_overflow();
    out_q.delete(); out_gap.delete();
    busy_len = 2;
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full_o); end
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL ovf_level16: got %0d expected 16", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow_o); end
    push(8'h20);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_o); end
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL ovf_level_after_drop: got %0d expected 16", level_o); end
    force_busy = 1'b0;
    wait_outputs(16, 400);
    repeat (10) tick();
    checks++; if (out_q.size() != 16) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (out_q[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, out_q[i], 8'h10 + 8'(i)); end
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_clear_overflow();
    clear_overflow_i = 1'b1;
    tick();
    clear_overflow_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_clears: got %b expected 0", overflow_o); end
    out_q.delete(); out_gap.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    clear_overflow_i = 1'b1;
    push(8'h3f);
    clear_overflow_i = 1'b0;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b expected 1", overflow_o); end
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL clr_level: got %0d expected 16", level_o); end
    clear_overflow_i = 1'b1;
    tick();
    clear_overflow_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_second: got %b expected 0", overflow_o); end
    force_busy = 1'b0;
    wait_outputs(16, 400);
    repeat (10) tick();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL clr_drain_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_push_pop_wrap();
    int n;
    out_q.delete(); out_gap.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    checks++; if (level_o !== 5'd5) begin errors++; $display("FAIL pp_level_before: got %0d expected 5", level_o); end
    force_busy = 1'b0;
    push(8'h55);
    checks++; if (level_o !== 5'd5) begin errors++; $display("FAIL pp_level_same: got %0d expected 5", level_o); end
    checks++; if (uart_wr_strobe_o !== 1'b1 || uart_data_o !== 8'h50) begin
      errors++; $display("FAIL pp_pop: got strobe=%b data=%h expected strobe=1 data=50", uart_wr_strobe_o, uart_data_o);
    end
    wait_outputs(6, 300);
    repeat (10) tick();
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL pp_count: got %0d expected 6", out_q.size()); end
    if (out_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_q[i] !== 8'h50 + 8'(i)) begin errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, out_q[i], 8'h50 + 8'(i)); end
      end
    end
    out_q.delete(); out_gap.delete();
    rand_busy = 1'b1;
    n = 0;
    for (int t = 0; t < 3000 && out_q.size() < 40; t++) begin
      if (n < 40 && full_o == 1'b0) begin
        wr_strobe_i = 1'b1;
        wr_data_i   = 8'(n);
        n++;
      end else begin
        wr_strobe_i = 1'b0;
      end
      tick();
    end
    wr_strobe_i = 1'b0;
    checks++; if (out_q.size() != 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", out_q.size()); end
    if (out_q.size() == 40) begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (out_q[i] !== 8'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, out_q[i], 8'(i)); end
      end
    end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow_o); end
    rand_busy = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    busy_len = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    force_busy = 1'b0;
    tick();
    force_busy = 1'b1;
    repeat (4) tick();
    checks++; if (level_o !== 5'd4) begin errors++; $display("FAIL rmid_level_before: got %0d expected 4", level_o); end
    out_q.delete(); out_gap.delete();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", level_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b expected 1", empty_o); end
    checks++; if (uart_wr_strobe_o !== 1'b0) begin errors++; $display("FAIL rmid_strobe: got %b expected 0", uart_wr_strobe_o); end
    force_busy = 1'b0;
    repeat (20) tick();
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL rmid_no_strobe: got %0d strobes expected 0", out_q.size()); end
    push(8'h77);
    wait_outputs(1, 50);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rmid_new_count: got %0d expected 1", out_q.size()); end
    if (out_q.size() == 1) begin
      checks++;
      if (out_q[0] !== 8'h77) begin errors++; $display("FAIL rmid_new_data: got %h expected 77", out_q[0]); end
    end
    repeat (10) tick();
  endtask

  initial begin
    rst_i            = 1'b1;
    wr_strobe_i      = 1'b0;
    wr_data_i        = 8'h00;
    clear_overflow_i = 1'b0;
    test_reset();
    test_single();
    test_abc();
    test_overflow();
    test_clear_overflow();
    test_push_pop_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
